// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM states, digit widths
// and the default button debounce length.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam int UNITS_W              = 4;
    localparam int TENS_W               = 3;
    localparam int DEBOUNCE_CYC_DEFAULT = 20000;

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchronizer, stable-count debouncer and
// a one-cycle press pulse on the debounced rising edge.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic PRESS
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_debPrev;
    logic [CNT_W-1:0] r_cnt;

    // Any sample that agrees with the accepted level restarts the count, so bounce is absorbed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb     <= 1'b0;
            r_debPrev <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= BTN;
            r_sync2   <= r_sync1;
            r_debPrev <= r_deb;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_deb <= ~r_deb;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign PRESS = r_deb & ~r_debPrev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button control: sequences idle/run/lap/stop, drives the counter's
// run enable and clear pulse, and freezes the displayed digits at a lap point.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               BTN_SS,
    input  logic               BTN_LC,
    input  logic [UNITS_W-1:0] NUM_1S,
    input  logic [TENS_W-1:0]  NUM_10S,
    output logic               START,
    output logic               CLR,
    output logic [UNITS_W-1:0] DISP_1S,
    output logic [TENS_W-1:0]  DISP_10S,
    output logic [1:0]         STATE
);

    logic w_ssPress;
    logic w_lcPress;

    state_t             r_state;
    logic               r_start;
    logic               r_clr;
    logic [UNITS_W-1:0] r_disp1s;
    logic [TENS_W-1:0]  r_disp10s;
    logic [UNITS_W-1:0] r_hold1s;
    logic [TENS_W-1:0]  r_hold10s;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ssBtn (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BTN   (BTN_SS),
        .PRESS (w_ssPress)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_lcBtn (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BTN   (BTN_LC),
        .PRESS (w_lcPress)
    );

    // Start/stop is checked first everywhere, so a coincident lap/clear press is dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_clr     <= 1'b0;
            r_disp1s  <= '0;
            r_disp10s <= '0;
            r_hold1s  <= '0;
            r_hold10s <= '0;
        end else begin
            r_clr     <= 1'b0;
            r_disp1s  <= NUM_1S;
            r_disp10s <= NUM_10S;
            case (r_state)
                ST_IDLE: begin
                    if (w_ssPress) begin
                        r_state <= ST_RUN;
                        r_start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_ssPress) begin
                        r_state <= ST_STOP;
                        r_start <= 1'b0;
                    end else if (w_lcPress) begin
                        r_state   <= ST_LAP;
                        r_hold1s  <= NUM_1S;
                        r_hold10s <= NUM_10S;
                    end
                end
                ST_LAP: begin
                    if (w_ssPress) begin
                        r_state <= ST_STOP;
                        r_start <= 1'b0;
                    end else if (w_lcPress) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_disp1s  <= r_hold1s;
                        r_disp10s <= r_hold10s;
                    end
                end
                ST_STOP: begin
                    if (w_ssPress) begin
                        r_state <= ST_RUN;
                        r_start <= 1'b1;
                    end else if (w_lcPress) begin
                        r_state <= ST_IDLE;
                        r_clr   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    assign START    = r_start;
    assign CLR      = r_clr;
    assign DISP_1S  = r_disp1s;
    assign DISP_10S = r_disp10s;
    assign STATE    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed button scenarios plus random
// button activity, compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int D = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       BTN_SS = 1'b0;
    logic       BTN_LC = 1'b0;
    logic [3:0] NUM_1S = '0;
    logic [2:0] NUM_10S = '0;
    logic       START;
    logic       CLR;
    logic [3:0] DISP_1S;
    logic [2:0] DISP_10S;
    logic [1:0] STATE;

    int assertCount = 0;
    int failCount = 0;

    logic [D+1:0] mSsWin, mLcWin;
    bit           mSsDeb, mLcDeb, mSsEvt, mLcEvt;
    int           mState, mHold1, mHold10, mDisp1, mDisp10;
    bit           mStart, mClr;

    stopwatch_ctrl #(.DEBOUNCE_CYC(D)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_SS   (BTN_SS),
        .BTN_LC   (BTN_LC),
        .NUM_1S   (NUM_1S),
        .NUM_10S  (NUM_10S),
        .START    (START),
        .CLR      (CLR),
        .DISP_1S  (DISP_1S),
        .DISP_10S (DISP_10S),
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mSsWin = '0; mLcWin = '0;
        mSsDeb = 0; mLcDeb = 0; mSsEvt = 0; mLcEvt = 0;
        mState = 0; mStart = 0; mClr = 0;
        mHold1 = 0; mHold10 = 0; mDisp1 = 0; mDisp10 = 0;
    endtask

    // A level is accepted once the synchronized samples of the last D cycles all oppose it.
    function automatic bit acceptsNewLevel(input logic [D+1:0] win, input bit deb);
        for (int k = 2; k <= D + 1; k++)
            if (win[k] == deb) return 0;
        return 1;
    endfunction

    task automatic modelEdge();
        bit ss, lc;
        ss = mSsEvt;
        lc = mLcEvt;
        mClr = 0;
        case (mState)
            0: if (ss) mState = 1;
            1: if (ss) mState = 3;
               else if (lc) begin mState = 2; mHold1 = NUM_1S; mHold10 = NUM_10S; end
            2: if (ss) mState = 3; else if (lc) mState = 1;
            default: if (ss) mState = 1; else if (lc) begin mState = 0; mClr = 1; end
        endcase
        mStart = (mState == 1) || (mState == 2);
        mDisp1  = (mState == 2) ? mHold1  : int'(NUM_1S);
        mDisp10 = (mState == 2) ? mHold10 : int'(NUM_10S);

        mSsWin = {mSsWin[D:0], BTN_SS};
        mLcWin = {mLcWin[D:0], BTN_LC};
        mSsEvt = 0;
        mLcEvt = 0;
        if (acceptsNewLevel(mSsWin, mSsDeb)) begin mSsDeb = ~mSsDeb; mSsEvt = mSsDeb; end
        if (acceptsNewLevel(mLcWin, mLcDeb)) begin mLcDeb = ~mLcDeb; mLcEvt = mLcDeb; end
    endtask

    task automatic compareAll();
        checkOutput("state", STATE, mState);
        checkOutput("start", START, mStart);
        checkOutput("clr", CLR, mClr);
        checkOutput("disp1s", DISP_1S, mDisp1);
        checkOutput("disp10s", DISP_10S, mDisp10);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic applyStimulus(input bit ss, input bit lc, input int n1, input int n10);
        BTN_SS = ss;
        BTN_LC = lc;
        NUM_1S = 4'(n1);
        NUM_10S = 3'(n10);
        @(posedge CLK);
        modelEdge();
        @(negedge CLK);
        compareAll();
    endtask

    task automatic stepRand(input bit ss, input bit lc);
        applyStimulus(ss, lc, $urandom_range(0, 9), $urandom_range(0, 5));
    endtask

    task automatic pressBtn(input bit ss, input bit lc, input int hold, input int rel);
        for (int i = 0; i < hold; i++) stepRand(ss, lc);
        for (int i = 0; i < rel; i++) stepRand(0, 0);
    endtask

    initial begin
        int clrCnt;
        bit ssLvl, lcLvl;

        modelReset();
        repeat (3) @(negedge CLK);
        checkOutput("reset_state", STATE, 0);
        checkOutput("reset_start", START, 0);
        checkOutput("reset_disp1s", DISP_1S, 0);
        RST_N = 1'b1;

        // Start: event lands on edge 7 after first sample, held press gives one event
        for (int i = 1; i <= 10; i++) begin
            stepRand(1, 0);
            if (i == 6) checkOutput("start_edge6_state", STATE, 0);
            if (i == 7) begin
                checkOutput("start_edge7_state", STATE, 1);
                checkOutput("start_edge7_start", START, 1);
            end
        end
        for (int i = 0; i < 8; i++) stepRand(0, 0);
        checkOutput("start_held_once", STATE, 1);

        // Glitch shorter than the debounce window, then a bouncing press
        pressBtn(1, 0, 3, 6);
        checkOutput("glitch_ignored", STATE, 1);
        stepRand(1, 0);
        stepRand(0, 0);
        for (int i = 1; i <= 8; i++) begin
            stepRand(1, 0);
            if (i == 6) checkOutput("bounce_edge6_state", STATE, 1);
            if (i == 7) checkOutput("bounce_edge7_state", STATE, 3);
        end
        for (int i = 0; i < 8; i++) stepRand(0, 0);

        pressBtn(1, 0, 8, 8);
        checkOutput("resume_run", STATE, 1);

        // Lap with NUM held at 2/7 across the lap edge, then counter advances
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 7, 2);
        for (int i = 0; i < 8; i++) stepRand(0, 0);
        checkOutput("lap_state", STATE, 2);
        checkOutput("lap_start", START, 1);
        checkOutput("lap_hold1s", DISP_1S, 7);
        checkOutput("lap_hold10s", DISP_10S, 2);
        pressBtn(0, 1, 8, 8);
        checkOutput("lap_exit_state", STATE, 1);

        // Stop then clear: CLR exactly one cycle, then lc in IDLE does nothing
        pressBtn(1, 0, 8, 8);
        checkOutput("stop_state", STATE, 3);
        checkOutput("stop_start", START, 0);
        clrCnt = 0;
        for (int i = 0; i < 16; i++) begin
            stepRand(0, (i < 8));
            clrCnt += int'(CLR);
        end
        checkOutput("clr_width", clrCnt, 1);
        checkOutput("clear_state", STATE, 0);
        pressBtn(0, 1, 8, 8);
        checkOutput("idle_lc_ignored", STATE, 0);

        // Simultaneous presses in RUN: start/stop wins
        pressBtn(1, 0, 8, 8);
        pressBtn(1, 1, 8, 8);
        checkOutput("simul_state", STATE, 3);

        // Random button activity with bounce and glitches
        ssLvl = 0;
        lcLvl = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) ssLvl = ~ssLvl;
            if ($urandom_range(0, 5) == 0) lcLvl = ~lcLvl;
            stepRand(ssLvl, lcLvl);
        end
        for (int i = 0; i < 10; i++) stepRand(0, 0);

        // Navigate to LAP, then assert reset between clock edges
        for (int t = 0; t < 4 && mState != 2; t++) begin
            if (mState == 1) pressBtn(0, 1, 8, 8);
            else pressBtn(1, 0, 8, 8);
        end
        checkOutput("lap_reached", STATE, 2);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("async_state", STATE, 0);
        checkOutput("async_start", START, 0);
        checkOutput("async_clr", CLR, 0);
        checkOutput("async_disp1s", DISP_1S, 0);
        checkOutput("async_disp10s", DISP_10S, 0);
        modelReset();
        BTN_SS = 0;
        BTN_LC = 0;
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            stepRand(1, 0);
            if (i == 6) checkOutput("post_reset_edge6", STATE, 0);
            if (i == 7) checkOutput("post_reset_edge7", STATE, 1);
        end
        for (int i = 0; i < 8; i++) stepRand(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
